seq_mul_div: RTL

Parametrised iterative multiply/divide unit for the MIPS datapath, and the successor to the fixed 32-bit start/busy multiplier.
- Adds signed and unsigned modes, division, a HI/LO result pair and a one-cycle done pulse.
- Runs radix-2 (one bit per cycle) and serves MULT/MULTU/DIV/DIVU.
- HI/LO feed MFHI/MFLO.

---
 rtl/mips_md_pkg.sv | 16 +
 rtl/seq_mul_div_if.sv | 23 ++
 rtl/md_sign_conv.sv | 15 +
 rtl/seq_mul_div.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
// Holds the op encodings (the op bus of the unit) and the FSM state type.
package mips_md_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } md_state_e;

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle of seq_mul_div.
//   start, op, a, b : request, driven by the master, latched by the unit on start
//   hi, lo          : result pair (remainder/quotient or product halves)
//   busy, done      : operation in progress / one-cycle completion pulse
//   div_zero        : divide with zero divisor, valid with done
interface seq_mul_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (output start, op, a, b,
                   input  hi, lo, busy, done, div_zero);
   modport slave  (input  start, op, a, b,
                   output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/md_sign_conv.sv
// Conditional two's-complement negate.
//   i_val : value in
//   i_neg : 1 = output -i_val, 0 = pass through
//   o_val : result, same width
// Used for operand magnitudes and for final sign correction. The magnitude of
// the most-negative value comes out as the unsigned 2^(WIDTH-1).
module md_sign_conv #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);
   assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/seq_mul_div.sv
// Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of seq_mul_div_if (start/op/a/b in; hi/lo/busy/done/
//          div_zero out)
// One bit per cycle on operand magnitudes; a final FIX cycle applies the
// result signs and writes hi/lo, pulsing done.
module seq_mul_div
   import mips_md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   seq_mul_div_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   md_state_e          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_neg_lo;   // sign of product / quotient
   logic               r_neg_hi;   // sign of remainder (follows dividend)
   logic               r_bzero;
   logic [WIDTH-1:0]   r_a_raw;
   // r_rem:r_q is the working register pair. Multiply: accumulator high part
   // (one carry bit) and multiplier shifting out of r_q. Divide: partial
   // remainder and dividend shifting into quotient.
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_opnd;     // multiplicand / divisor magnitude
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_dz;

   logic               w_signed;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shl;
   logic               w_ge;
   logic [WIDTH:0]     w_sub;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = bus.op[0];

   md_sign_conv #(.WIDTH(WIDTH)) u_mag_a (
      .i_val (bus.a),
      .i_neg (w_signed & bus.a[WIDTH-1]),
      .o_val (w_mag_a)
   );

   md_sign_conv #(.WIDTH(WIDTH)) u_mag_b (
      .i_val (bus.b),
      .i_neg (w_signed & bus.b[WIDTH-1]),
      .o_val (w_mag_b)
   );

   // multiply step: conditional add, then shift the pair right
   assign w_add = r_rem + {1'b0, (r_q[0] ? r_opnd : '0)};

   // divide step: shift the pair left, trial-subtract the divisor
   assign w_shl = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_ge  = (w_shl >= {1'b0, r_opnd});
   assign w_sub = w_shl - {1'b0, r_opnd};

   md_sign_conv #(.WIDTH(2*WIDTH)) u_fix_prod (
      .i_val ({r_rem[WIDTH-1:0], r_q}),
      .i_neg (r_neg_lo),
      .o_val (w_prod)
   );

   md_sign_conv #(.WIDTH(WIDTH)) u_fix_quo (
      .i_val (r_q),
      .i_neg (r_neg_lo),
      .o_val (w_quo)
   );

   md_sign_conv #(.WIDTH(WIDTH)) u_fix_rem (
      .i_val (r_rem[WIDTH-1:0]),
      .i_neg (r_neg_hi),
      .o_val (w_rem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_bzero  <= 1'b0;
         r_a_raw  <= '0;
         r_rem    <= '0;
         r_q      <= '0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state  <= RUN;
                  r_busy   <= 1'b1;
                  r_cnt    <= CNT_W'(WIDTH);
                  r_is_div <= bus.op[1];
                  r_neg_lo <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  r_neg_hi <= w_signed & bus.a[WIDTH-1];
                  r_bzero  <= (bus.b == '0);
                  r_a_raw  <= bus.a;
                  r_rem    <= '0;
                  r_q      <= w_mag_a;
                  r_opnd   <= w_mag_b;
               end
            end
            RUN: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_is_div) begin
                  r_rem <= w_ge ? w_sub : w_shl;
                  r_q   <= {r_q[WIDTH-2:0], w_ge};
               end else begin
                  r_rem <= {1'b0, w_add[WIDTH:1]};
                  r_q   <= {w_add[0], r_q[WIDTH-1:1]};
               end
               if (r_cnt == CNT_W'(1))
                  r_state <= FIX;
            end
            FIX: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               if (r_is_div && r_bzero) begin
                  // zero divisor: fixed pattern, dividend passed through raw
                  r_hi <= r_a_raw;
                  r_lo <= '1;
                  r_dz <= 1'b1;
               end else if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
                  r_dz <= 1'b0;
               end else begin
                  {r_hi, r_lo} <= w_prod;
                  r_dz <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.div_zero = r_dz;

endmodule
